keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Upstream input stage of the code-lock path. Scans a 4x4 active-low matrix keypad,
//  synchronises and debounces the row lines, and emits one 4-bit key code per physical
//  press as a single-cycle strobe. The lock-checking stage consumes key_code/key_valid.
// PARAMETERS
//  SCAN_CYCLES      4    clk cycles each column is driven before rows are sampled (>=3)
//  DEBOUNCE_CYCLES  16   consecutive stable samples required for press and for release (>=2)
// PORTS
//  clk       in   1  clock
//  rst       in   1  asynchronous, active-low reset
//  enable    in   1  1 = scanning active; 0 = idle, all columns released
//  row_in    in   4  keypad rows, active-low (pulled up externally), asynchronous to clk
//  col_out   out  4  keypad column drive, active-low, at most one bit low
//  key_code  out  4  {row_idx[1:0], col_idx[1:0]} of last accepted key (= row*4 + col)
//  key_valid out  1  one-cycle pulse: key_code is a new debounced press
//  key_held  out  1  high from the accept pulse until release debounce completes
// BEHAVIOUR
//  Reset: state=SCAN, col_idx=0, col_out=4'b1110, key_code=4'h0, key_valid=0,
//   key_held=0, all counters 0, both synchroniser stages 4'b1111.
//  Sync: row_in passes a 2-flop synchroniser -> rows_s (2 cycles latency). All decisions use rows_s.
//  Counters: dwell_cnt width $clog2(SCAN_CYCLES); deb_cnt width $clog2(DEBOUNCE_CYCLES+1).
//  col_out = ~(4'b0001 << col_idx) whenever enable=1; 4'b1111 whenever enable=0.
//  State SCAN: dwell_cnt counts 0..SCAN_CYCLES-1. At dwell_cnt==SCAN_CYCLES-1 sample rows_s:
//   - exactly one bit low -> capture pattern + row_idx, deb_cnt<=0, go DEBOUNCE; col_idx frozen.
//   - all high or >=2 bits low (ghost/multi-key) -> col_idx<=col_idx+1 (3 wraps to 0), dwell_cnt<=0.
//  State DEBOUNCE: each cycle, rows_s==captured -> deb_cnt++; else -> SCAN with
//   col_idx<=col_idx+1, dwell_cnt<=0, no pulse. When the match makes deb_cnt==DEBOUNCE_CYCLES:
//   next cycle key_valid=1 (one cycle), key_code<={row_idx,col_idx}, key_held=1, go PRESSED.
//  State PRESSED: column stays driven; key_valid=0. When rows_s==4'b1111 -> deb_cnt<=0, go RELEASE.
//   Any other row activity (second key) is ignored; no further pulses while held.
//  State RELEASE: rows_s==4'b1111 -> deb_cnt++; any bit low -> deb_cnt<=0, stay (re-bounce).
//   deb_cnt==DEBOUNCE_CYCLES -> key_held<=0, col_idx<=0, dwell_cnt<=0, go SCAN.
//  key_code holds its value until the next accepted press (not cleared on release).
//  Press-to-pulse latency from stable row_in: <= 2 sync + full scan pass + DEBOUNCE_CYCLES + 1.
//  Release-to-key_held-low: 2 sync + DEBOUNCE_CYCLES + 1 cycles.
//  enable=0 (any state, any cycle): next cycle state=SCAN, col_idx=0, counters 0, key_held=0,
//   key_valid=0, key_code retained; an in-progress press is discarded without a pulse.
//   On enable re-assert scanning restarts at column 0; a key still down is re-debounced.
//  rst low mid-operation: all state returns to reset values immediately (async), no pulse.
//  key_valid never asserts on two consecutive cycles.
// TESTING
//  1 Reset: rst=0 -> col_out=4'b1110, key_code=0, key_valid=0, key_held=0; release rst,
//    no keys -> col_out rotates 1110,1101,1011,0111,1110 every SCAN_CYCLES cycles.
//  2 Clean press row2/col1 (row_in=4'b1011 while col_out=4'b1101), hold 200 cycles ->
//    exactly one key_valid pulse with key_code=4'h9, key_held=1 until 2+16+1 cycles after release.
//  3 Bounce: row toggles every 5 cycles for 60 cycles, then stable 40 cycles -> no pulse during
//    bounce, exactly one pulse after stable; release bounce of 10 cycles -> key_held stays 1, no pulse.
//  4 Multi-key: rows 0 and 3 low on column 2 -> no pulse, scan keeps rotating; then single row 3
//    on column 2 -> one pulse, key_code=4'hE.
//  5 Abort: enable=0 at deb_cnt=8 -> col_out=4'b1111 next cycle, no pulse, key_code unchanged;
//    enable=1 with key still down -> one pulse after re-debounce.
//  6 Async reset in PRESSED (key_code=4'h5) -> outputs to reset values same cycle; key held
//    through rst release -> exactly one new pulse, key_code=4'h5.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: row synchroniser, column scan, press/release
// debounce, and a single-cycle strobe per accepted key press.
module keypad_scanner #(
  parameter int unsigned SCAN_CYCLES     = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned DwellW = $clog2(SCAN_CYCLES);
  localparam int unsigned DebW   = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [DwellW-1:0] DwellLast = DwellW'(SCAN_CYCLES - 1);
  localparam logic [DwellW-1:0] DwellOne  = DwellW'(1);
  localparam logic [DebW-1:0]   DebLast   = DebW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DebW-1:0]   DebOne    = DebW'(1);

  typedef enum logic [1:0] {StScan, StDebounce, StPressed, StRelease} state_e;

  state_e            state_q, state_d;
  logic [1:0]        col_idx_q, col_idx_d;
  logic [DwellW-1:0] dwell_q, dwell_d;
  logic [DebW-1:0]   deb_q, deb_d;
  logic [3:0]        pat_q, pat_d;
  logic [1:0]        row_idx_q, row_idx_d;
  logic [3:0]        key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
  logic              key_held_q, key_held_d;
  logic [3:0]        sync1_q, rows_s;

  logic              one_low;
  logic [1:0]        row_sel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StScan;
      col_idx_q   <= '0;
      dwell_q     <= '0;
      deb_q       <= '0;
      pat_q       <= 4'b1111;
      row_idx_q   <= '0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      sync1_q     <= 4'b1111;
      rows_s      <= 4'b1111;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      dwell_q     <= dwell_d;
      deb_q       <= deb_d;
      pat_q       <= pat_d;
      row_idx_q   <= row_idx_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      sync1_q     <= row_in;
      rows_s      <= sync1_q;
    end
  end

  // Only a single low row is a valid key; none or several (ghosting) means keep scanning.
  always_comb begin
    one_low = 1'b1;
    row_sel = 2'd0;
    case (rows_s)
      4'b1110: row_sel = 2'd0;
      4'b1101: row_sel = 2'd1;
      4'b1011: row_sel = 2'd2;
      4'b0111: row_sel = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    dwell_d     = dwell_q;
    deb_d       = deb_q;
    pat_d       = pat_q;
    row_idx_d   = row_idx_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    if (!enable) begin
      state_d    = StScan;
      col_idx_d  = '0;
      dwell_d    = '0;
      deb_d      = '0;
      key_held_d = 1'b0;
    end else begin
      unique case (state_q)
        StScan: begin
          if (dwell_q == DwellLast) begin
            dwell_d = '0;
            if (one_low) begin
              pat_d     = rows_s;
              row_idx_d = row_sel;
              deb_d     = '0;
              state_d   = StDebounce;
            end else begin
              col_idx_d = col_idx_q + 2'd1;
            end
          end else begin
            dwell_d = dwell_q + DwellOne;
          end
        end
        StDebounce: begin
          if (rows_s == pat_q) begin
            deb_d = deb_q + DebOne;
            if (deb_q == DebLast) begin
              key_valid_d = 1'b1;
              key_code_d  = {row_idx_q, col_idx_q};
              key_held_d  = 1'b1;
              state_d     = StPressed;
            end
          end else begin
            state_d   = StScan;
            col_idx_d = col_idx_q + 2'd1;
            dwell_d   = '0;
          end
        end
        StPressed: begin
          if (rows_s == 4'b1111) begin
            deb_d   = '0;
            state_d = StRelease;
          end
        end
        StRelease: begin
          if (rows_s == 4'b1111) begin
            if (deb_q == DebLast) begin
              deb_d      = '0;
              key_held_d = 1'b0;
              col_idx_d  = '0;
              dwell_d    = '0;
              state_d    = StScan;
            end else begin
              deb_d = deb_q + DebOne;
            end
          end else begin
            deb_d = '0;
          end
        end
        default: state_d = StScan;
      endcase
    end
  end

  assign col_out   = enable ? ~(4'b0001 << col_idx_q) : 4'b1111;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: emulated key matrix, timing-level reference model checked
// every cycle, plus directed literal checks of scan order, codes, pulse counts and latency.
module tb_keypad_scanner;

  localparam int S = 4;
  localparam int D = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] keys = '0;  // keys[row*4+col] = 1 while that key is physically down
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;

  keypad_scanner #(.SCAN_CYCLES(S), .DEBOUNCE_CYCLES(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .row_in   (row_in),
    .col_out  (col_out),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  // A row reads low when any pressed key on it sits in a column currently driven low.
  always_comb begin
    row_in = 4'b1111;
    for (int r = 0; r < 4; r++) row_in[r] = ~|(keys[r*4 +: 4] & ~col_out);
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: modes 0 scan, 1 verify press, 2 held, 3 verify release.
  int         m_mode = 0;
  int         m_col = 0;
  int         m_elapsed = 0;
  int         m_run = 0;
  int         m_row = 0;
  logic [3:0] m_pat = 4'hF;
  logic [3:0] m_code = 4'h0;
  logic       m_valid = 1'b0;
  logic       m_held = 1'b0;
  logic [3:0] pipe[2] = '{4'hF, 4'hF};

  always @(posedge clk) begin : model
    logic [3:0] seen, rin, low, exp_col;
    logic       en, rn;
    rin = row_in;
    en  = enable;
    rn  = rst;
    if (!rn) begin
      m_mode = 0; m_col = 0; m_elapsed = 0; m_run = 0; m_row = 0;
      m_code = 4'h0; m_valid = 1'b0; m_held = 1'b0; pipe[0] = 4'hF; pipe[1] = 4'hF;
    end else begin
      seen    = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = rin;
      low     = ~seen;
      m_valid = 1'b0;
      if (!en) begin
        m_mode = 0; m_col = 0; m_elapsed = 0; m_run = 0; m_held = 1'b0;
      end else if (m_mode == 0) begin
        m_elapsed++;
        if (m_elapsed == S) begin
          m_elapsed = 0;
          if ($countones(low) == 1) begin
            m_pat = seen;
            for (int r = 0; r < 4; r++) if (low[r]) m_row = r;
            m_run  = 0;
            m_mode = 1;
          end else m_col = (m_col + 1) % 4;
        end
      end else if (m_mode == 1) begin
        if (seen == m_pat) begin
          m_run++;
          if (m_run == D) begin
            m_valid = 1'b1;
            m_held  = 1'b1;
            m_code  = 4'(m_row * 4 + m_col);
            m_mode  = 2;
          end
        end else begin
          m_mode = 0; m_col = (m_col + 1) % 4; m_elapsed = 0;
        end
      end else if (m_mode == 2) begin
        if (seen == 4'hF) begin m_run = 0; m_mode = 3; end
      end else begin
        if (seen == 4'hF) begin
          m_run++;
          if (m_run == D) begin
            m_held = 1'b0; m_col = 0; m_elapsed = 0; m_run = 0; m_mode = 0;
          end
        end else m_run = 0;
      end
    end
    #2;
    if (key_valid === 1'b1) pulses++;
    exp_col = 4'b0001 << m_col;
    exp_col = enable ? ~exp_col : 4'hF;
    check("col_out", col_out, exp_col);
    check("key_code", key_code, m_code);
    check("key_valid", {3'b0, key_valid}, {3'b0, m_valid});
    check("key_held", {3'b0, key_held}, {3'b0, m_held});
  end

  initial begin : stim
    int p0;
    logic [3:0] seen_cols, exp_rot;
    bit hit;

    // Reset values and free-running rotation
    enable = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_col", col_out, 4'b1110);
    check("rst_code", key_code, 4'h0);
    check("rst_valid", {3'b0, key_valid}, 4'h0);
    check("rst_held", {3'b0, key_held}, 4'h0);
    rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      exp_rot = 4'b0001 << ((k / S) % 4);
      check("rotate", col_out, ~exp_rot);
      @(negedge clk);
    end

    // Clean press row2/col1, then release latency
    p0 = pulses;
    keys[9] = 1'b1;
    repeat (200) @(negedge clk);
    check("press_pulses", 4'(pulses - p0), 4'd1);
    check("press_code", key_code, 4'h9);
    check("model_code", m_code, 4'h9);
    check("press_held", {3'b0, key_held}, 4'h1);
    keys = '0;
    repeat (18) @(negedge clk);
    check("held_before", {3'b0, key_held}, 4'h1);
    @(negedge clk);
    check("held_after", {3'b0, key_held}, 4'h0);

    // Bouncing press on row1/col3, then bouncing release
    repeat (10) @(negedge clk);
    p0 = pulses;
    for (int i = 0; i < 12; i++) begin
      keys[7] = ~keys[7];
      repeat (5) @(negedge clk);
    end
    check("bounce_nopulse", 4'(pulses - p0), 4'd0);
    keys[7] = 1'b1;
    repeat (40) @(negedge clk);
    check("bounce_pulse", 4'(pulses - p0), 4'd1);
    check("bounce_code", key_code, 4'h7);
    for (int i = 0; i < 10; i++) begin
      keys[7] = ~keys[7];
      @(negedge clk);
    end
    check("rel_bounce_held", {3'b0, key_held}, 4'h1);
    check("rel_bounce_pulses", 4'(pulses - p0), 4'd1);
    keys = '0;
    repeat (30) @(negedge clk);
    check("rel_done", {3'b0, key_held}, 4'h0);

    // Ghost: rows 0 and 3 on column 2
    p0 = pulses;
    seen_cols = '0;
    keys[2]  = 1'b1;
    keys[14] = 1'b1;
    for (int i = 0; i < 60; i++) begin
      seen_cols |= ~col_out;
      @(negedge clk);
    end
    check("ghost_nopulse", 4'(pulses - p0), 4'd0);
    check("ghost_rotates", seen_cols, 4'hF);
    keys[2] = 1'b0;
    repeat (60) @(negedge clk);
    check("single_pulse", 4'(pulses - p0), 4'd1);
    check("single_code", key_code, 4'hE);
    keys = '0;
    repeat (30) @(negedge clk);

    // Abort mid-debounce with enable, then re-debounce
    p0 = pulses;
    keys[3] = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (m_mode == 1 && m_run == 8) hit = 1'b1;
    end
    check("abort_reached", {3'b0, hit}, 4'h1);
    enable = 1'b0;
    @(negedge clk);
    check("abort_cols", col_out, 4'b1111);
    repeat (5) @(negedge clk);
    check("abort_nopulse", 4'(pulses - p0), 4'd0);
    check("abort_code", key_code, 4'hE);
    enable = 1'b1;
    repeat (60) @(negedge clk);
    check("reen_pulse", 4'(pulses - p0), 4'd1);
    check("reen_code", key_code, 4'h3);
    keys = '0;
    repeat (30) @(negedge clk);

    // Async reset while a key is held
    p0 = pulses;
    keys[5] = 1'b1;
    repeat (60) @(negedge clk);
    check("pre_rst_code", key_code, 4'h5);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_col", col_out, 4'b1110);
    check("arst_code", key_code, 4'h0);
    check("arst_valid", {3'b0, key_valid}, 4'h0);
    check("arst_held", {3'b0, key_held}, 4'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (60) @(negedge clk);
    check("post_rst_pulses", 4'(pulses - p0), 4'd2);
    check("post_rst_code", key_code, 4'h5);
    keys = '0;
    repeat (30) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
